// File: rtl/filter_coef_loader.sv
// filter_coef_loader
//   Coefficient controller for a TAPS-tap FIR filter. Holds NBANK coefficient
//   banks written by a host, streams a requested bank into the filter's
//   coefficient write port, and mutes the sample stream while coefficients
//   are changing and while the filter pipeline flushes.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   cfg_we/bank/idx/data host write into bank storage
//   cfg_err              1-cycle pulse: host write rejected
//   load_req/load_bank   level request to load a bank into the filter
//   load_ack             1-cycle pulse: request accepted (also LOAD cycle 0)
//   busy                 high during LOAD and FLUSH
//   done                 1-cycle pulse: load + flush complete
//   coef_valid           filter holds a completely loaded bank
//   h_write/h_idx/h_data filter coefficient write port
//   x_in_src / x_in_flt  sample in / muted sample out (combinational)
module filter_coef_loader #(
    parameter int TAPS      = 32,
    parameter int IDX_W     = 5,
    parameter int DW        = 16,
    parameter int NBANK     = 4,
    parameter int BANK_W    = 2,
    parameter int FLUSH_CYC = 38
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [BANK_W-1:0] cfg_bank,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DW-1:0]     cfg_data,
    output logic              cfg_err,
    input  logic              load_req,
    input  logic [BANK_W-1:0] load_bank,
    output logic              load_ack,
    output logic              busy,
    output logic              done,
    output logic              coef_valid,
    output logic              h_write,
    output logic [IDX_W-1:0]  h_idx,
    output logic [DW-1:0]     h_data,
    input  logic [DW-1:0]     x_in_src,
    output logic [DW-1:0]     x_in_flt
);
    localparam int CNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [IDX_W:0]   TAPS_L   = TAPS[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] FLUSH_L  = CNT_W'(FLUSH_CYC);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_ack_q, load_ack_d;
    logic               cfg_err_q, cfg_err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               coef_valid_q, coef_valid_d;
    logic               h_write_q, h_write_d;
    logic [IDX_W-1:0]   h_idx_q, h_idx_d;
    logic [DW-1:0]      h_data_q, h_data_d;
    logic [DW-1:0]      mem_q [NBANK][TAPS];

    logic idx_ok, wr_ok, fwd0;

    // A write to the bank currently being streamed would tear the set, so it
    // is refused; every other in-range write lands.
    assign idx_ok = ({1'b0, cfg_idx} < TAPS_L);
    assign wr_ok  = cfg_we && idx_ok && !(state_q == S_LOAD && cfg_bank == bank_q);
    // Same-edge host write to tap 0 of the bank being accepted: stream the new word.
    assign fwd0   = cfg_we && (cfg_bank == load_bank) && (cfg_idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NBANK; b++)
                for (int t = 0; t < TAPS; t++)
                    mem_q[b][t] <= '0;
        end else if (wr_ok) begin
            mem_q[cfg_bank][cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bank_q       <= '0;
            cnt_q        <= '0;
            load_ack_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            coef_valid_q <= 1'b0;
            h_write_q    <= 1'b0;
            h_idx_q      <= '0;
            h_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            cnt_q        <= cnt_d;
            load_ack_q   <= load_ack_d;
            cfg_err_q    <= cfg_err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            coef_valid_q <= coef_valid_d;
            h_write_q    <= h_write_d;
            h_idx_q      <= h_idx_d;
            h_data_q     <= h_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        cnt_d        = cnt_q;
        load_ack_d   = 1'b0;
        done_d       = 1'b0;
        coef_valid_d = coef_valid_q;
        h_write_d    = 1'b0;
        h_idx_d      = h_idx_q;
        h_data_d     = h_data_q;
        cfg_err_d    = cfg_we && !wr_ok;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    // Tap 0 is driven together with the ack.
                    state_d      = S_LOAD;
                    bank_d       = load_bank;
                    load_ack_d   = 1'b1;
                    coef_valid_d = 1'b0;
                    h_write_d    = 1'b1;
                    h_idx_d      = '0;
                    h_data_d     = fwd0 ? cfg_data : mem_q[load_bank][0];
                end
            end
            S_LOAD: begin
                if (h_idx_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    h_write_d = 1'b1;
                    h_idx_d   = h_idx_q + 1'b1;
                    h_data_d  = mem_q[bank_q][h_idx_q + 1'b1];
                end
            end
            S_FLUSH: begin
                // Counting 0..FLUSH_CYC inclusive gives the accept-to-done
                // latency of 1 + TAPS + FLUSH_CYC edges.
                if (cnt_q == FLUSH_L) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    coef_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign cfg_err    = cfg_err_q;
    assign load_ack   = load_ack_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign coef_valid = coef_valid_q;
    assign h_write    = h_write_q;
    assign h_idx      = h_idx_q;
    assign h_data     = h_data_q;
    assign x_in_flt   = (state_q == S_IDLE && coef_valid_q) ? x_in_src : '0;
endmodule

// File: tb/tb_filter_coef_loader.sv
module tb_filter_coef_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_bank = '0;
    logic [4:0]  cfg_idx = '0;
    logic [15:0] cfg_data = '0;
    logic        load_req = 1'b0;
    logic [1:0]  load_bank = '0;
    logic [15:0] x_in_src = 16'h1234;

    logic        cfg_err, load_ack, busy, done, coef_valid, h_write;
    logic [4:0]  h_idx;
    logic [15:0] h_data, x_in_flt;
    logic        cfg_err2, load_ack2, busy2, done2, coef_valid2, h_write2;
    logic [4:0]  h_idx2;
    logic [15:0] h_data2, x_in_flt2;

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] mdl [4][32];
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];

    always #5 clk = ~clk;

    filter_coef_loader dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .load_req(load_req), .load_bank(load_bank),
        .load_ack(load_ack), .busy(busy), .done(done), .coef_valid(coef_valid),
        .h_write(h_write), .h_idx(h_idx), .h_data(h_data), .x_in_src(x_in_src),
        .x_in_flt(x_in_flt)
    );

    filter_coef_loader #(.TAPS(24), .FLUSH_CYC(30)) dut24 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_err(cfg_err2), .load_req(load_req), .load_bank(load_bank),
        .load_ack(load_ack2), .busy(busy2), .done(done2), .coef_valid(coef_valid2),
        .h_write(h_write2), .h_idx(h_idx2), .h_data(h_data2), .x_in_src(x_in_src),
        .x_in_flt(x_in_flt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 4; b++)
            for (int t = 0; t < 32; t++)
                mdl[b][t] = '0;
    endtask

    // Accepted host write (tracked in the model).
    task automatic cfg_write(input logic [1:0] b, input logic [4:0] i, input logic [15:0] d);
        cfg_we = 1'b1; cfg_bank = b; cfg_idx = i; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        mdl[b][i] = d;
    endtask

    // Requests bank b, pushes the expected stream from the model and collects
    // the observed stream; cycle numbers count edges, the accepting edge is 1.
    task automatic load_run(input logic [1:0] b, output int ack_at, output int ack_cnt,
                            output int done_at, output int mute_bad);
        int c;
        for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), mdl[b][k]});
        obs_q.delete();
        load_req = 1'b1; load_bank = b;
        c = 0; ack_at = -1; ack_cnt = 0; done_at = -1; mute_bad = 0;
        while (done_at < 0 && c < 300) begin
            tick(); c++;
            if (load_ack) begin ack_cnt++; if (ack_at < 0) ack_at = c; load_req = 1'b0; end
            if (h_write) obs_q.push_back({h_idx, h_data});
            if (busy && x_in_flt !== 16'h0) mute_bad++;
            if (done) done_at = c;
        end
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({cfg_err, load_ack, busy, done, coef_valid, h_write, h_idx, h_data} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {cfg_err, load_ack, busy, done, coef_valid, h_write, h_idx, h_data});
        else n_pass++;
        #3 reset = 1'b0;
        tick();
        n_chk++;
        if (x_in_flt !== 16'h0 || busy !== 1'b0)
            $display("FAIL reset_mute: x_in_flt=%h busy=%b want 0/0", x_in_flt, busy);
        else n_pass++;
    endtask

    task automatic test_load();
        int ack_at, ack_cnt, done_at, mute_bad, errs;
        logic [20:0] e, o;
        errs = 0;
        for (int k = 0; k < 32; k++) begin
            cfg_write(2'd1, 5'(k), 16'h0100 + 16'(k));
            if (cfg_err !== 1'b0) errs++;
        end
        n_chk++;
        if (errs != 0) $display("FAIL load_cfg_err: got %0d rejected writes want 0", errs);
        else n_pass++;
        load_run(2'd1, ack_at, ack_cnt, done_at, mute_bad);
        n_chk++;
        if (ack_at != 1 || ack_cnt != 1)
            $display("FAIL load_ack: at %0d count %0d want 1/1", ack_at, ack_cnt);
        else n_pass++;
        n_chk++;
        if (done_at != 72)
            $display("FAIL load_latency: done %0d edges after accept want 71", done_at - 1);
        else n_pass++;
        n_chk++;
        if (obs_q.size() != 32) $display("FAIL load_count: got %0d writes want 32", obs_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 21'h1FFFFF;
            n_chk++;
            if (o !== e) $display("FAIL load_stream: got idx/data %h want %h", o, e);
            else n_pass++;
        end
        n_chk++;
        if (mute_bad != 0 || coef_valid !== 1'b1 || x_in_flt !== x_in_src)
            $display("FAIL load_mute: mute_bad=%0d cv=%b x_in_flt=%h want 0/1/%h",
                     mute_bad, coef_valid, x_in_flt, x_in_src);
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        int ack_at, ack_cnt, done_at, mute_bad, c;
        logic [20:0] e, o;
        load_req = 1'b1; load_bank = 2'd1;
        tick();
        load_req = 1'b0;
        cfg_we = 1'b1; cfg_bank = 2'd1; cfg_idx = 5'd3; cfg_data = 16'hDEAD;
        tick();
        cfg_we = 1'b0;
        n_chk++;
        if (cfg_err !== 1'b1) $display("FAIL cfg_err_same_bank: got %b want 1", cfg_err);
        else n_pass++;
        cfg_write(2'd2, 5'd3, 16'hBEEF);
        n_chk++;
        if (cfg_err !== 1'b0) $display("FAIL cfg_err_other_bank: got %b want 0", cfg_err);
        else n_pass++;
        c = 0;
        while (done !== 1'b1 && c < 200) begin tick(); c++; end
        n_chk++;
        if (done !== 1'b1) $display("FAIL cfg_err_done_timeout: done=%b want 1", done);
        else n_pass++;
        for (int b = 1; b <= 2; b++) begin
            load_run(2'(b), ack_at, ack_cnt, done_at, mute_bad);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 21'h1FFFFF;
                if (e[20:16] == 5'd3) begin
                    n_chk++;
                    if (o !== e) $display("FAIL cfg_err_reload: bank %0d got %h want %h", b, o, e);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, ack1, ack2, done_at, mute_bad;
        c = 0; ack1 = -1; ack2 = -1; done_at = -1; mute_bad = 0;
        load_req = 1'b1; load_bank = 2'd1;
        while (ack2 < 0 && c < 300) begin
            tick(); c++;
            if (load_ack) begin if (ack1 < 0) ack1 = c; else ack2 = c; end
            if (done && done_at < 0) done_at = c;
            if (busy && x_in_flt !== 16'h0) mute_bad++;
        end
        load_req = 1'b0;
        n_chk++;
        if (ack1 != 1 || done_at != 72 || ack2 != done_at + 1)
            $display("FAIL b2b_ack: ack1=%0d done=%0d ack2=%0d want 1/72/73", ack1, done_at, ack2);
        else n_pass++;
        while (done !== 1'b1 && c < 400) begin
            tick(); c++;
            if (busy && x_in_flt !== 16'h0) mute_bad++;
        end
        n_chk++;
        if (mute_bad != 0 || done !== 1'b1)
            $display("FAIL b2b_mute: unmuted busy cycles %0d done=%b want 0/1", mute_bad, done);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int c, ack_at, ack_cnt, done_at, mute_bad, nz;
        logic [20:0] e, o;
        load_req = 1'b1; load_bank = 2'd1;
        c = 0;
        tick();
        load_req = 1'b0;
        while (h_idx !== 5'd10 && c < 50) begin tick(); c++; end
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if (h_write !== 1'b0 || coef_valid !== 1'b0 || busy !== 1'b0 || x_in_flt !== 16'h0)
            $display("FAIL mid_reset: hw=%b cv=%b busy=%b xf=%h want 0/0/0/0",
                     h_write, coef_valid, busy, x_in_flt);
        else n_pass++;
        #3 reset = 1'b0;
        clear_model();
        tick();
        n_chk++;
        if (x_in_flt !== 16'h0) $display("FAIL mid_reset_mute: got %h want 0", x_in_flt);
        else n_pass++;
        load_run(2'd1, ack_at, ack_cnt, done_at, mute_bad);
        nz = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 21'h1FFFFF;
            if (o !== e) nz++;
        end
        n_chk++;
        if (nz != 0 || x_in_flt !== x_in_src)
            $display("FAIL mid_reset_reload: bad taps %0d xf=%h want 0/%h", nz, x_in_flt, x_in_src);
        else n_pass++;
    endtask

    task automatic test_taps24();
        int c, cnt, done_at;
        logic [20:0] e, o;
        reset = 1'b1;
        tick();
        #3 reset = 1'b0;
        clear_model();
        tick();
        for (int k = 0; k < 24; k++) cfg_write(2'd0, 5'(k), 16'h0600 + 16'(k));
        cfg_we = 1'b1; cfg_bank = 2'd0; cfg_idx = 5'd24; cfg_data = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        n_chk++;
        if (cfg_err2 !== 1'b1 || cfg_err !== 1'b0)
            $display("FAIL taps24_idx_err: err24=%b err32=%b want 1/0", cfg_err2, cfg_err);
        else n_pass++;
        for (int k = 0; k < 24; k++) exp_q.push_back({5'(k), mdl[0][k]});
        obs_q.delete();
        load_req = 1'b1; load_bank = 2'd0;
        c = 0; cnt = 0; done_at = -1;
        while (done_at < 0 && c < 200) begin
            tick(); c++;
            if (load_ack2) load_req = 1'b0;
            if (h_write2) begin cnt++; obs_q.push_back({h_idx2, h_data2}); end
            if (done2) done_at = c;
        end
        load_req = 1'b0;
        n_chk++;
        if (cnt != 24 || done_at != 56)
            $display("FAIL taps24_stream: writes=%0d done=%0d want 24/56", cnt, done_at);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 21'h1FFFFF;
            n_chk++;
            if (o !== e) $display("FAIL taps24_data: got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_load();
        test_cfg_err();
        test_back_to_back();
        test_reset_mid_load();
        test_taps24();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
